// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: a one-deep fetch buffer between instruction memory and decode.
// It handles branch redirects (including late flushes of an in-flight fetch), exception entry/return, and halt.
module pc_fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [15:0] instr,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        siic,
  input  logic        rti,
  input  logic        halt,
  output logic [15:0] epc_value,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, FETCH, HOLD, DRAIN, HALT} state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] epc_q;
  logic [15:0] instr_q;
  logic        req_q;
  logic        valid_q;
  logic        halted_q;
  logic        err_q;
  logic [15:0] pc_inc;
  logic [15:0] target;

  assign pc_inc = pc_q + 16'd2;
  // Branch targets are always forced even; a set bit 0 is only reported via err.
  assign target = {redirect_pc[15:1], 1'b0};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      epc_q    <= '0;
      instr_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (redirect_valid) begin
            // Late flush: the in-flight word is stale; wait it out in DRAIN unless it lands now.
            pc_q  <= target;
            err_q <= redirect_pc[0];
            if (!imem_done) begin
              state_q <= DRAIN;
              req_q   <= 1'b0;
            end
          end else if (imem_done) begin
            instr_q <= imem_data;
            state_q <= HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (id_ready) begin
            valid_q <= 1'b0;
            state_q <= FETCH;
            req_q   <= 1'b1;
            if (siic) begin
              epc_q <= pc_inc;
              pc_q  <= 16'h0002;
            end else if (rti) begin
              pc_q <= epc_q;
            end else if (halt) begin
              state_q  <= HALT;
              req_q    <= 1'b0;
              halted_q <= 1'b1;
            end else if (redirect_valid) begin
              pc_q  <= target;
              err_q <= redirect_pc[0];
            end else begin
              pc_q <= pc_inc;
            end
          end
        end
        DRAIN: begin
          if (redirect_valid) begin
            pc_q  <= target;
            err_q <= redirect_pc[0];
          end
          if (imem_done) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        HALT: state_q <= HALT;
        default: begin
          state_q  <= IDLE;
          req_q    <= 1'b0;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign pc_plus2  = pc_inc;
  assign epc_value = epc_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl: a latency-varying memory agent plus a transaction-level
// model of the architectural pc/epc, the held instruction and the fetch/drain/halt status.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        if_valid;
  logic        id_ready;
  logic [15:0] instr;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        siic;
  logic        rti;
  logic        halt;
  logic [15:0] epc_value;
  logic        halted;
  logic        err;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_done      (imem_done),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .instr          (instr),
    .pc             (pc),
    .pc_plus2       (pc_plus2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .siic           (siic),
    .rti            (rti),
    .halt           (halt),
    .epc_value      (epc_value),
    .halted         (halted),
    .err            (err)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state: describes the DUT as it should look after the next rising edge.
  logic [15:0] m_pc;
  logic [15:0] m_epc;
  logic [15:0] req_addr;
  bit          held;
  bit          outstanding;
  bit          draining;
  bit          m_halted;
  bit          err_exp;
  int          cnt;

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] pick_target();
    logic [15:0] t;
    t = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       t = 16'hFFFE;
      1:       t = t | 16'h0001;
      default: t = t;
    endcase
    return t;
  endfunction

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc        = '0;
    m_epc       = '0;
    held        = 1'b0;
    outstanding = 1'b0;
    draining    = 1'b0;
    m_halted    = 1'b0;
    err_exp     = 1'b0;
    cnt         = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    imem_done      = 1'b1;
    imem_data      = 16'hDEAD;
    id_ready       = 1'b1;
    siic           = 1'b0;
    rti            = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0101;
    @(negedge clk);
    chk("rst_req",    16'(imem_req), 16'd0);
    chk("rst_valid",  16'(if_valid), 16'd0);
    chk("rst_halted", 16'(halted),   16'd0);
    chk("rst_err",    16'(err),      16'd0);
    chk("rst_pc",     pc,            16'h0000);
    chk("rst_epc",    epc_value,     16'h0000);
    chk("rst_instr",  instr,         16'h0000);
    // Leave the stale response and stray controls up through the first cycle out of reset.
    rst = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit allow_halt);
    bit done_now;
    bit acc;
    @(negedge clk);
    chk("if_valid", 16'(if_valid), 16'(held));
    chk("halted",   16'(halted),   16'(m_halted));
    chk("imem_req", 16'(imem_req), 16'(!m_halted && !held && !draining));
    chk("err",      16'(err),      16'(err_exp));
    chk("pc",       pc,            m_pc);
    chk("pc_plus2", pc_plus2,      m_pc + 16'd2);
    chk("epc",      epc_value,     m_epc);
    if (imem_req) chk("imem_addr", imem_addr, m_pc);
    if (held)     chk("instr",     instr,     memfn(m_pc));

    err_exp        = 1'b0;
    done_now       = 1'b0;
    imem_done      = 1'b0;
    imem_data      = 16'($urandom);
    id_ready       = 1'b0;
    siic           = 1'b0;
    rti            = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = pick_target();

    if (m_halted) begin
      {imem_done, id_ready, siic, rti, halt, redirect_valid} = 6'($urandom);
      return;
    end

    if (imem_req && !outstanding) begin
      outstanding = 1'b1;
      req_addr    = imem_addr;
      cnt         = $urandom_range(0, 3);
    end
    if (outstanding) begin
      if (cnt == 0) begin
        done_now  = 1'b1;
        imem_done = 1'b1;
        imem_data = memfn(req_addr);
      end else begin
        cnt--;
      end
    end else if (held) begin
      imem_done = ($urandom_range(0, 3) == 0);
    end

    if (outstanding && $urandom_range(0, 7) == 0) begin
      redirect_valid = 1'b1;
      m_pc           = redirect_pc & 16'hFFFE;
      err_exp        = redirect_pc[0];
      if (done_now) begin
        outstanding = 1'b0;
        draining    = 1'b0;
      end else begin
        draining = 1'b1;
      end
    end else if (done_now) begin
      outstanding = 1'b0;
      if (draining) draining = 1'b0;
      else          held     = 1'b1;
    end else if (held) begin
      acc            = ($urandom_range(0, 9) < 7);
      id_ready       = acc;
      siic           = ($urandom_range(0, 6) == 0);
      rti            = ($urandom_range(0, 6) == 0);
      halt           = allow_halt && ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 3) == 0);
      if (acc) begin
        held = 1'b0;
        if (siic) begin
          m_epc = m_pc + 16'd2;
          m_pc  = 16'h0002;
        end else if (rti) begin
          m_pc = m_epc;
        end else if (halt) begin
          m_halted = 1'b1;
        end else if (redirect_valid) begin
          m_pc    = redirect_pc & 16'hFFFE;
          err_exp = redirect_pc[0];
        end else begin
          m_pc = m_pc + 16'd2;
        end
      end
    end
  endtask

  initial begin
    rst            = 1'b0;
    imem_done      = 1'b0;
    imem_data      = '0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    siic           = 1'b0;
    rti            = 1'b0;
    halt           = 1'b0;
    model_reset();

    do_reset();
    repeat (3000) step(1'b0);

    for (int i = 0; i < 3000 && !m_halted; i++) step(1'b1);
    step(1'b1);
    chk("halt_reached", 16'(halted), 16'd1);
    repeat (8) step(1'b1);

    do_reset();
    repeat (400) step(1'b0);

    // Reset landing while a flushed fetch is still being drained.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 500 && !draining; i++) step(1'b0);
      do_reset();
      repeat (50) step(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock for all state; rising-edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous and active-low, sampled on rising clk.
REQ-003 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-004 SHALL have port: imem_addr  output  16  fetch address; equals pc.
REQ-005 SHALL have port: imem_done  input  1  memory returns imem_data this cycle.
REQ-006 SHALL have port: imem_data  input  16  fetched instruction word.
REQ-007 SHALL have port: if_valid  output  1  instr/pc/pc_plus2 valid for decode.
REQ-008 SHALL have port: id_ready  input  1  decode accepts held instruction.
REQ-009 SHALL have port: instr  output  16  held instruction.
REQ-010 SHALL have port: pc, pc_plus2  output  16 each  address of held instruction and that value +2.
REQ-011 SHALL have port: redirect_valid, redirect_pc  input  1/16  taken branch/jump target from next-PC adder.
REQ-012 SHALL have port: siic, rti, halt  input  1 each  decode of accepted instruction is exception-entry / return / halt.
REQ-013 SHALL have port: epc_value  output  16  saved exception PC, fed back to next-PC adder.
REQ-014 SHALL have port: halted, err  output  1 each  halt reached; misaligned-target pulse.

Function
REQ-015 SHALL implement states IDLE, FETCH, HOLD, DRAIN, HALT.
REQ-016 IDLE: all outputs 0; next cycle -> FETCH.
REQ-017 FETCH: imem_req=1, imem_addr=pc; on imem_done capture imem_data into instr, -> HOLD.
REQ-018 HOLD: if_valid=1, imem_req=0; on id_ready with no control event, pc<=pc+2, -> FETCH.
REQ-019 Control events evaluated only on an id_ready cycle in HOLD; priority siic > rti > halt > redirect_valid.
REQ-020 siic: epc<=pc_plus2, pc<=0x0002, -> FETCH.
REQ-021 rti: pc<=epc, -> FETCH; epc unchanged.
REQ-022 halt: pc unchanged, -> HALT; HALT holds halted=1, imem_req=0, if_valid=0 until reset; all inputs ignored.
REQ-023 redirect_valid: pc<={redirect_pc[15:1],1'b0}, -> FETCH.
REQ-024 redirect_valid asserted while in FETCH (late flush): pc<=target; if imem_done same cycle, data discarded, -> FETCH; else -> DRAIN.
REQ-025 DRAIN: imem_req=0; wait for imem_done, discard imem_data, -> FETCH at new pc; further redirects in DRAIN overwrite pc, stay DRAIN.
REQ-026 redirect_pc[0]=1 SHALL pulse err for exactly one cycle; target still forced even.
REQ-027 pc arithmetic SHALL be 16-bit modulo: pc=0xFFFE advances to 0x0000, pc_plus2 of 0xFFFE is 0x0000; no err.
REQ-028 if_valid SHALL drop the cycle after acceptance; at most one instruction held; no combinational path imem_done->if_valid.
REQ-029 instr, pc, pc_plus2 SHALL stay stable while if_valid=1 and id_ready=0.
REQ-030 pc_plus2 SHALL be combinational pc+2; epc_value SHALL be the epc register directly.

Reset
REQ-031 rst=0 at a clk edge SHALL force state IDLE, pc=0x0000, epc=0x0000, instr=0x0000, err=0, halted=0, imem_req=0, if_valid=0, from any state including DRAIN and HALT.
REQ-032 A memory response arriving during or after reset, before a new request, SHALL be ignored.
REQ-033 First fetch after rst release SHALL be address 0x0000, imem_req high on second cycle after release.

Verification
REQ-034 Sequential: release reset, imem_done 1 cycle after each req, id_ready=1 -> addresses 0x0000,0x0002,0x0004 accepted in order; if_valid never held two cycles with id_ready=1.
REQ-035 Exception round trip: at pc=0x0010 accept with siic=1 -> epc_value=0x0012, next fetch 0x0002; later accept with rti=1 -> next fetch 0x0012.
REQ-036 Late flush: in FETCH at 0x0020, imem_done delayed 3 cycles, redirect_pc=0x0100 -> DRAIN, stale word discarded, next req at 0x0100, instr from 0x0020 never valid.
REQ-037 Priority/misalign: siic=1 with redirect_valid=1, redirect_pc=0x0041 -> pc=0x0002, err=0; redirect alone to 0x0041 -> pc=0x0040, err one-cycle pulse.
REQ-038 Wrap and halt: pc=0xFFFE accepted -> next fetch 0x0000; accept with halt=1 -> halted=1, no further req; rst=0 mid-HALT -> IDLE, pc=0x0000.
